// File: rtl/pwm_pkg.sv
// Shared defaults and helpers for the multi-channel PWM generator.
package pwm_pkg;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_RES     = 8;
  localparam int DEF_PRESC_W = 8;

  // Width of the channel-select field; a single channel still needs one bit.
  function automatic int ch_width(input int n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

  localparam int CH_W = ch_width(DEF_N_CH);

  typedef logic [DEF_RES-1:0] duty_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty pair, pending flag, compare and output flop.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int RES = DEF_RES
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [RES-1:0] cnt,
  input  logic           load,
  input  logic           wr,
  input  logic [RES-1:0] duty_val,
  input  logic           ch_en,
  input  logic           polarity,
  output logic           pwm_out,
  output logic           pending
);

  logic [RES-1:0] shadow;
  logic [RES-1:0] active;

  // NOTE: the duty registers are plain flops, not a memory, so they are reset with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
      pwm_out <= 1'b0;
    end else begin
      if (wr) shadow <= duty_val;
      // A write landing on the boundary bypasses the shadow so it is not lost for a period.
      if (load) begin
        active  <= wr ? duty_val : shadow;
        pending <= 1'b0;
      end else if (wr) begin
        pending <= 1'b1;
      end
      pwm_out <= ((cnt < active) & ch_en & ena) ^ polarity;
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM: prescaler tick enable, shared period counter, write decode, period strobe.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int RES     = DEF_RES,
  parameter int PRESC_W = DEF_PRESC_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [PRESC_W-1:0]         prescale,
  input  logic                       duty_wr,
  input  logic [ch_width(N_CH)-1:0]  duty_ch,
  input  logic [RES-1:0]             duty_val,
  input  logic [N_CH-1:0]            ch_en,
  input  logic [N_CH-1:0]            polarity,
  output logic [N_CH-1:0]            pwm_out,
  output logic                       period_start,
  output logic [N_CH-1:0]            duty_pending
);

  localparam int CH_BITS = ch_width(N_CH);
  // Last count value before wrap: 2^RES-2, giving a period of 2^RES-1 ticks.
  localparam logic [RES-1:0] CNT_LAST = {{(RES-1){1'b1}}, 1'b0};

  logic [PRESC_W-1:0] presc_cnt;
  logic [RES-1:0]     cnt;
  logic               tick;
  logic               wrap;

  // >= rather than == so lowering prescale below presc_cnt ticks at once instead of wrapping around.
  assign tick = ena && (presc_cnt >= prescale);
  assign wrap = tick && (cnt == CNT_LAST);

  // NOTE: sequential state uses <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_cnt    <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= wrap;
      if (ena)  presc_cnt <= tick ? '0 : presc_cnt + PRESC_W'(1);
      if (tick) cnt       <= wrap ? '0 : cnt + RES'(1);
    end
  end

  // Out-of-range channel numbers match no instance, so such writes fall away.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pwm_channel #(.RES(RES)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .cnt      (cnt),
      .load     (wrap),
      .wr       (duty_wr && (duty_ch == CH_BITS'(i))),
      .duty_val (duty_val),
      .ch_en    (ch_en[i]),
      .polarity (polarity[i]),
      .pwm_out  (pwm_out[i]),
      .pending  (duty_pending[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench for pwm_multi_channel: behavioural model, per-cycle compare, directed and random stimulus.
module tb_pwm_multi_channel;
  import pwm_pkg::*;

  localparam int N_CH   = 5;           // non power of two so channel numbers 5..7 are out of range
  localparam int RES    = 8;
  localparam int PERIOD = (1 << RES) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              ena = 1'b0;
  logic [7:0]        prescale = '0;
  logic              duty_wr = 1'b0;
  logic [2:0]        duty_ch = '0;
  duty_t             duty_val = '0;
  logic [N_CH-1:0]   ch_en = '0;
  logic [N_CH-1:0]   polarity = '0;
  logic [N_CH-1:0]   pwm_out;
  logic              period_start;
  logic [N_CH-1:0]   duty_pending;

  pwm_multi_channel #(.N_CH(N_CH), .RES(RES), .PRESC_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .prescale     (prescale),
    .duty_wr      (duty_wr),
    .duty_ch      (duty_ch),
    .duty_val     (duty_val),
    .ch_en        (ch_en),
    .polarity     (polarity),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .duty_pending (duty_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_on   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Behavioural model: integer counters and arrays derived from the tick/wrap rules.
  int              m_presc;
  int              m_cnt;
  int              m_shadow [N_CH];
  int              m_active [N_CH];
  logic [N_CH-1:0] m_pending;
  logic [N_CH-1:0] m_pwm;
  logic            m_ps;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_presc   <= 0;
      m_cnt     <= 0;
      m_pending <= '0;
      m_pwm     <= '0;
      m_ps      <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        m_shadow[i] <= 0;
        m_active[i] <= 0;
      end
    end else begin : step
      bit tick;
      bit wrap;
      bit wr_ok;
      int nxt;
      tick  = ena && (m_presc >= int'(prescale));
      wrap  = tick && (m_cnt == PERIOD - 1);
      wr_ok = duty_wr && (int'(duty_ch) < N_CH);
      m_ps <= wrap;
      if (ena)  m_presc <= tick ? 0 : m_presc + 1;
      if (tick) m_cnt   <= wrap ? 0 : m_cnt + 1;
      for (int i = 0; i < N_CH; i++) begin
        m_pwm[i] <= ((m_cnt < m_active[i]) && ch_en[i] && ena) ^ polarity[i];
        nxt = (wr_ok && int'(duty_ch) == i) ? int'(duty_val) : m_shadow[i];
        m_shadow[i] <= nxt;
        if (wrap) begin
          m_active[i]  <= nxt;
          m_pending[i] <= 1'b0;
        end else if (wr_ok && int'(duty_ch) == i) begin
          m_pending[i] <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("pwm_out", 32'(pwm_out), 32'(m_pwm));
      check("period_start", 32'(period_start), 32'(m_ps));
      check("duty_pending", 32'(duty_pending), 32'(m_pending));
    end
  end

  // Stimulus helpers; all are entered and left on a falling edge.
  task automatic write_duty(input int ch, input int val);
    duty_wr  = 1'b1;
    duty_ch  = 3'(ch);
    duty_val = duty_t'(val);
    @(negedge clk);
    duty_wr  = 1'b0;
  endtask

  task automatic wait_ps(input string name, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (period_start) return;
    end
    timeout_fail(name);
  endtask

  task automatic wait_cnt(input string name, input int target, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (m_cnt == target) return;
    end
    timeout_fail(name);
  endtask

  // Starting on a period_start edge, count clocks to the next one and high cycles of one channel.
  task automatic measure_period(input int ch, output int interval, output int highs);
    highs    = int'(pwm_out[ch]);
    interval = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      interval++;
      if (period_start) return;
      highs += int'(pwm_out[ch]);
    end
    timeout_fail("measure_period");
  endtask

  int iv, hi, hi1, hi2, idle_ok, ps_seen, k6;

  initial begin
    #1 rst = 1'b1;
    cmp_on = 1'b1;
    #1;
    check("reset pwm_out", 32'(pwm_out), 32'h0);
    check("reset period_start", 32'(period_start), 32'h0);
    check("reset duty_pending", 32'(duty_pending), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // T1: 128/255 duty on ch0 with prescale 0
    ena = 1'b1; ch_en = '1; polarity = '0; prescale = 8'd0;
    write_duty(0, 128);
    check("t1 pending set", 32'(duty_pending), 32'b00001);
    wait_ps("t1 wait", 300);
    check("t1 pending cleared", 32'(duty_pending), 32'h0);
    measure_period(0, iv, hi);
    check("t1 period", iv, PERIOD);
    check("t1 high", hi, 128);

    // T2: duty 0 and full-scale, then inverted
    write_duty(1, 0);
    write_duty(2, 255);
    wait_ps("t2 wait", 300);
    hi1 = 0; hi2 = 0;
    repeat (3 * PERIOD) begin
      @(negedge clk);
      hi1 += int'(pwm_out[1]);
      hi2 += int'(pwm_out[2]);
    end
    check("t2 ch1 high", hi1, 0);
    check("t2 ch2 high", hi2, 3 * PERIOD);
    polarity = 5'b00110;
    hi1 = 0; hi2 = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      hi1 += int'(pwm_out[1]);
      hi2 += int'(pwm_out[2]);
    end
    check("t2 inv ch1 high", hi1, PERIOD);
    check("t2 inv ch2 high", hi2, 0);
    polarity = '0;

    // T3: mid-period write is held until the wrap
    wait_cnt("t3 wait cnt", 100, 300);
    write_duty(0, 64);
    check("t3 pending", 32'(duty_pending), 32'b00001);
    wait_ps("t3 wait", 300);
    measure_period(0, iv, hi);
    check("t3 period", iv, PERIOD);
    check("t3 high", hi, 64);

    // T4: write coincident with the wrap tick, then out-of-range channels
    wait_cnt("t4 wait cnt", PERIOD - 1, 300);
    write_duty(1, 200);
    check("t4 period_start", 32'(period_start), 32'h1);
    check("t4 pending", 32'(duty_pending), 32'h0);
    measure_period(1, iv, hi);
    check("t4 high", hi, 200);
    write_duty(7, 99);
    check("t4 ch7 ignored", 32'(duty_pending), 32'h0);
    write_duty(5, 17);
    write_duty(6, 33);
    check("t4 ch5/6 ignored", 32'(duty_pending), 32'h0);

    // T5: prescale 3, then ena low for 50 clocks
    prescale = 8'd3;
    write_duty(3, 10);
    wait_ps("t5 wait", 1200);
    measure_period(3, iv, hi);
    check("t5 period", iv, 4 * PERIOD);
    check("t5 high", hi, 40);
    polarity = 5'b01010;
    ena = 1'b0;
    @(negedge clk);
    idle_ok = 0; ps_seen = 0;
    write_duty(4, 50);
    repeat (48) begin
      @(negedge clk);
      if (pwm_out == 5'b01010) idle_ok++;
      if (period_start) ps_seen++;
    end
    check("t5 idle level", idle_ok, 48);
    check("t5 no period_start", ps_seen, 0);
    check("t5 write while idle", 32'(duty_pending), 32'b10000);
    polarity = '0;
    ena = 1'b1;
    wait_ps("t5 resume", 1200);
    measure_period(3, iv, hi);
    check("t5 resume period", iv, 4 * PERIOD);
    check("t5 resume high", hi, 40);

    // T6: asynchronous reset mid-period
    prescale = 8'd0;
    wait_ps("t6 settle", 1200);
    wait_cnt("t6 wait cnt", 200, 300);
    #2 rst = 1'b1;
    #1;
    check("t6 pwm_out", 32'(pwm_out), 32'h0);
    check("t6 period_start", 32'(period_start), 32'h0);
    check("t6 pending", 32'(duty_pending), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    k6 = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (period_start) begin
        k6 = k;
        break;
      end
    end
    check("t6 first period_start", k6, PERIOD);

    // Random phase against the model
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          if ($urandom_range(0, 3) == 0) write_duty($urandom_range(0, 7), ($urandom_range(0, 1) == 1) ? 255 : 0);
          else write_duty($urandom_range(0, 7), $urandom_range(0, 255));
        end
        6: begin
          ch_en    = N_CH'($urandom);
          polarity = N_CH'($urandom);
        end
        7: prescale = 8'($urandom_range(0, 3));
        8: ena = ~ena;
        default: ;
      endcase
      repeat ($urandom_range(1, 15)) @(negedge clk);
    end
    ena = 1'b1;
    repeat (20) @(negedge clk);

    cmp_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
